// File: rtl/cam_controller.sv
// Small content-addressable memory: ENTRIES compare cells plus a valid bit per entry,
// sequenced through a single valid/ready request port with registered responses.

module cam_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             cmp_en_i,
  input  logic [WIDTH-1:0] key_i,
  output logic             match_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (we_i) begin
      data_d = wdata_i;
    end
  end

  // Storage cells carry no reset; only the controller's valid bits are cleared.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign match_o = cmp_en_i && (data_q == key_i);

endmodule

module cam_controller #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 8,
  parameter int AW      = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [WIDTH-1:0] req_data_i,
  output logic             rsp_valid_o,
  output logic [1:0]       rsp_op_o,
  output logic             rsp_hit_o,
  output logic [AW-1:0]    rsp_index_o,
  output logic             rsp_multi_o,
  output logic             rsp_err_o
);

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SEARCH = 2'b01,
    OP_INVAL  = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_CLEAR
  } state_e;

  // One extra bit so the bound compare also works when ENTRIES is a power of two.
  localparam logic [AW:0] ENTRIES_W = (AW+1)'(ENTRIES);
  localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);

  state_e               state_d, state_q;
  logic [ENTRIES-1:0]   valid_d, valid_q;
  logic [WIDTH-1:0]     key_d, key_q;
  logic [AW-1:0]        clr_idx_d, clr_idx_q;

  logic                 rsp_valid_d, rsp_valid_q;
  logic [1:0]           rsp_op_d, rsp_op_q;
  logic                 rsp_hit_d, rsp_hit_q;
  logic [AW-1:0]        rsp_index_d, rsp_index_q;
  logic                 rsp_multi_d, rsp_multi_q;
  logic                 rsp_err_d, rsp_err_q;

  logic [ENTRIES-1:0]   cell_we;
  logic [WIDTH-1:0]     cell_wdata;
  logic                 cmp_en;
  logic [ENTRIES-1:0]   cell_match;
  logic [ENTRIES-1:0]   match_vec;

  logic                 accept;
  logic                 addr_oob;
  op_e                  req_op;

  logic                 hit_c;
  logic [AW-1:0]        idx_c;
  logic                 multi_c;

  assign req_ready_o = (state_q == S_IDLE) && !reset;
  assign accept      = req_valid_i && req_ready_o;
  assign req_op      = op_e'(req_op_i);
  assign addr_oob    = ({1'b0, req_addr_i} >= ENTRIES_W);
  assign cmp_en      = (state_q == S_SEARCH);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cell
    cam_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk      (clk),
      .we_i     (cell_we[g]),
      .wdata_i  (cell_wdata),
      .cmp_en_i (cmp_en),
      .key_i    (key_q),
      .match_o  (cell_match[g])
    );
  end

  assign match_vec = cell_match & valid_q;

  // Lowest-index priority encode; a second hit flags multi.
  always_comb begin
    hit_c   = 1'b0;
    idx_c   = '0;
    multi_c = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (match_vec[i]) begin
        if (hit_c) begin
          multi_c = 1'b1;
        end else begin
          hit_c = 1'b1;
          idx_c = AW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    key_d       = key_q;
    clr_idx_d   = clr_idx_q;
    cell_we     = '0;
    cell_wdata  = req_data_i;
    rsp_valid_d = 1'b0;
    rsp_op_d    = '0;
    rsp_hit_d   = 1'b0;
    rsp_index_d = '0;
    rsp_multi_d = 1'b0;
    rsp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_WRITE, OP_INVAL: begin
              rsp_valid_d = 1'b1;
              rsp_op_d    = req_op_i;
              rsp_err_d   = addr_oob;
              if (!addr_oob) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                  if (req_addr_i == AW'(i)) begin
                    cell_we[i] = (req_op == OP_WRITE);
                    valid_d[i] = (req_op == OP_WRITE);
                  end
                end
              end
            end
            OP_SEARCH: begin
              key_d   = req_data_i;
              state_d = S_SEARCH;
            end
            OP_CLEAR: begin
              clr_idx_d = '0;
              state_d   = S_CLEAR;
            end
            default: ;
          endcase
        end
      end

      S_SEARCH: begin
        rsp_valid_d = 1'b1;
        rsp_op_d    = OP_SEARCH;
        rsp_hit_d   = hit_c;
        rsp_index_d = idx_c;
        rsp_multi_d = multi_c;
        state_d     = S_IDLE;
      end

      S_CLEAR: begin
        cell_wdata = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          if (clr_idx_q == AW'(i)) begin
            cell_we[i] = 1'b1;
            valid_d[i] = 1'b0;
          end
        end
        if (clr_idx_q == LAST_IDX) begin
          rsp_valid_d = 1'b1;
          rsp_op_d    = OP_CLEAR;
          state_d     = S_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      key_q       <= '0;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_multi_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      key_q       <= key_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
      rsp_multi_q <= rsp_multi_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_op_o    = rsp_op_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_index_o = rsp_index_q;
  assign rsp_multi_o = rsp_multi_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_cam_controller.sv
// Bench for cam_controller: an 8-entry and a 6-entry instance, vectors with fixed
// expected responses queued at accept time and matched against each response pulse.

module tb_cam_controller;

  localparam int W  = 8;
  localparam int AW = 3;

  localparam logic [1:0] OPW = 2'b00;
  localparam logic [1:0] OPS = 2'b01;
  localparam logic [1:0] OPI = 2'b10;
  localparam logic [1:0] OPC = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_data = '0;
  logic          req_valid_a = 1'b0;
  logic          req_valid_b = 1'b0;

  logic          ready_a, rsp_valid_a, hit_a, multi_a, err_a;
  logic [1:0]    rop_a;
  logic [AW-1:0] idx_a;
  logic          ready_b, rsp_valid_b, hit_b, multi_b, err_b;
  logic [1:0]    rop_b;
  logic [AW-1:0] idx_b;

  always #5 clk = ~clk;

  cam_controller #(.WIDTH(W), .ENTRIES(8)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_a), .req_ready_o(ready_a), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid_a), .rsp_op_o(rop_a), .rsp_hit_o(hit_a),
    .rsp_index_o(idx_a), .rsp_multi_o(multi_a), .rsp_err_o(err_a)
  );

  cam_controller #(.WIDTH(W), .ENTRIES(6)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_b), .req_ready_o(ready_b), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid_b), .rsp_op_o(rop_b), .rsp_hit_o(hit_b),
    .rsp_index_o(idx_b), .rsp_multi_o(multi_b), .rsp_err_o(err_b)
  );

  typedef struct {
    string         name;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          hit;
    logic [AW-1:0] idx;
    logic          multi;
    logic          err;
  } vec_t;

  typedef struct {
    string         name;
    logic [1:0]    op;
    logic          hit;
    logic [AW-1:0] idx;
    logic          multi;
    logic          err;
    int unsigned   cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int unsigned cyc = 0;
  int unsigned seen_a = 0;
  int unsigned seen_b = 0;
  int pass_cnt = 0;
  int chk_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input string name, input logic [1:0] op, input logic [AW-1:0] addr,
                              input logic [W-1:0] data, input logic hit, input logic [AW-1:0] idx,
                              input logic multi, input logic err);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.data = data;
    v.hit = hit; v.idx = idx; v.multi = multi; v.err = err;
    return v;
  endfunction

  task automatic chk(input bit ok, input string name, input string got, input string want);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %s, want %s", name, got, want);
  endtask

  task automatic score(input exp_t e, input logic [1:0] op, input logic hit, input logic [AW-1:0] idx,
                       input logic multi, input logic err, input int unsigned c);
    bit ok;
    ok = (op == e.op) && (hit == e.hit) && (idx == e.idx) && (multi == e.multi) &&
         (err == e.err) && (c == e.cyc);
    chk(ok, e.name,
        $sformatf("op=%0d hit=%0b idx=%0d multi=%0b err=%0b cyc=%0d", op, hit, idx, multi, err, c),
        $sformatf("op=%0d hit=%0b idx=%0d multi=%0b err=%0b cyc=%0d",
                  e.op, e.hit, e.idx, e.multi, e.err, e.cyc));
  endtask

  always @(negedge clk) begin
    if (rsp_valid_a) begin
      seen_a++;
      if (qa.size() == 0) chk(1'b0, "A unexpected rsp", "rsp_valid=1", "rsp_valid=0");
      else score(qa.pop_front(), rop_a, hit_a, idx_a, multi_a, err_a, cyc);
    end
    if (rsp_valid_b) begin
      seen_b++;
      if (qb.size() == 0) chk(1'b0, "B unexpected rsp", "rsp_valid=1", "rsp_valid=0");
      else score(qb.pop_front(), rop_b, hit_b, idx_b, multi_b, err_b, cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input bit sel, input vec_t v, input bit expect_rsp);
    int unsigned n;
    bit ok;
    exp_t e;
    int unsigned lat;
    req_op = v.op; req_addr = v.addr; req_data = v.data;
    if (sel) req_valid_b = 1'b1;
    else req_valid_a = 1'b1;
    @(negedge clk);
    n = 0;
    ok = 1'b1;
    while (!(sel ? ready_b : ready_a) && ok) begin
      n++;
      if (n > 40) begin
        chk(1'b0, {v.name, " accept"}, "ready low 40 cycles", "ready high");
        ok = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    lat = (v.op == OPS) ? 2 : (v.op == OPC) ? (sel ? 7 : 9) : 1;
    e.name = v.name; e.op = v.op; e.hit = v.hit; e.idx = v.idx;
    e.multi = v.multi; e.err = v.err; e.cyc = cyc + lat;
    if (ok && expect_rsp) begin
      if (sel) qb.push_back(e);
      else qa.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(qa.size() == 0 && qb.size() == 0, "drain",
        $sformatf("pending=%0d/%0d", qa.size(), qb.size()), "pending=0/0");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    int unsigned lowcnt;
    int unsigned s0;

    tbl[0]  = mk("wr3_a5",        OPW, 3, 8'hA5, 0, 0, 0, 0);
    tbl[1]  = mk("srch_a5",       OPS, 0, 8'hA5, 1, 3, 0, 0);
    tbl[2]  = mk("wr5_3c",        OPW, 5, 8'h3C, 0, 0, 0, 0);
    tbl[3]  = mk("wr1_3c",        OPW, 1, 8'h3C, 0, 0, 0, 0);
    tbl[4]  = mk("srch_3c_multi", OPS, 0, 8'h3C, 1, 1, 1, 0);
    tbl[5]  = mk("inv1",          OPI, 1, 8'h00, 0, 0, 0, 0);
    tbl[6]  = mk("srch_3c_after", OPS, 0, 8'h3C, 1, 5, 0, 0);
    tbl[7]  = mk("srch_77_miss",  OPS, 0, 8'h77, 0, 0, 0, 0);
    tbl[8]  = mk("wr0_a5",        OPW, 0, 8'hA5, 0, 0, 0, 0);
    tbl[9]  = mk("srch_a5_multi", OPS, 0, 8'hA5, 1, 0, 1, 0);
    tbl[10] = mk("inv3",          OPI, 3, 8'h00, 0, 0, 0, 0);
    tbl[11] = mk("srch_a5_idx0",  OPS, 0, 8'hA5, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(ready_a == 1'b0, "ready in reset", $sformatf("%0b", ready_a), "0");
    chk({rsp_valid_a, rop_a, hit_a, idx_a, multi_a, err_a} == '0, "rsp in reset",
        $sformatf("%b", {rsp_valid_a, rop_a, hit_a, idx_a, multi_a, err_a}), "0");
    step();
    reset = 1'b0;
    @(negedge clk);
    chk(ready_a == 1'b1, "ready after reset", $sformatf("%0b", ready_a), "1");
    step();

    for (int i = 0; i < 12; i++) send(1'b0, tbl[i], 1'b1);

    // Write/invalidate/search on consecutive accepts; ready drops for exactly one cycle.
    send(1'b0, mk("wr7_99", OPW, 7, 8'h99, 0, 0, 0, 0), 1'b1);
    send(1'b0, mk("inv7",   OPI, 7, 8'h00, 0, 0, 0, 0), 1'b1);
    send(1'b0, mk("srch_99_miss", OPS, 0, 8'h99, 0, 0, 0, 0), 1'b1);
    @(negedge clk);
    chk(ready_a == 1'b0, "search ready low", $sformatf("%0b", ready_a), "0");
    @(negedge clk);
    chk(ready_a == 1'b1, "search ready back", $sformatf("%0b", ready_a), "1");
    step();

    // Reset clears valid bits even though a cell still holds 0x00.
    send(1'b0, mk("wr2_00", OPW, 2, 8'h00, 0, 0, 0, 0), 1'b1);
    drain();
    reset = 1'b1;
    step();
    reset = 1'b0;
    send(1'b0, mk("srch_00_post_reset", OPS, 0, 8'h00, 0, 0, 0, 0), 1'b1);
    send(1'b0, mk("srch_3c_post_reset", OPS, 0, 8'h3C, 0, 0, 0, 0), 1'b1);

    for (int i = 0; i < 8; i++)
      send(1'b0, mk($sformatf("fill%0d", i), OPW, AW'(i), W'(8'h10 + i), 0, 0, 0, 0), 1'b1);
    send(1'b0, mk("srch_13_full", OPS, 0, 8'h13, 1, 3, 0, 0), 1'b1);
    send(1'b0, mk("clear", OPC, 0, 8'h00, 0, 0, 0, 0), 1'b1);
    @(negedge clk);
    lowcnt = 0;
    while (!ready_a && lowcnt < 20) begin
      lowcnt++;
      @(negedge clk);
    end
    chk(lowcnt == 8, "clear ready low cycles", $sformatf("%0d", lowcnt), "8");
    step();
    for (int i = 0; i < 8; i++)
      send(1'b0, mk($sformatf("srch_after_clear%0d", i), OPS, 0, W'(8'h10 + i), 0, 0, 0, 0), 1'b1);
    send(1'b0, mk("srch_00_after_clear", OPS, 0, 8'h00, 0, 0, 0, 0), 1'b1);

    // Reset in the middle of a CLEAR: no response, ready right after reset.
    send(1'b0, mk("wr4_c3", OPW, 4, 8'hC3, 0, 0, 0, 0), 1'b1);
    drain();
    s0 = seen_a;
    send(1'b0, mk("clear_aborted", OPC, 0, 8'h00, 0, 0, 0, 0), 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk(ready_a == 1'b1, "ready after clear abort", $sformatf("%0b", ready_a), "1");
    repeat (12) step();
    chk(seen_a == s0, "no rsp for aborted clear", $sformatf("%0d pulses", seen_a - s0), "0 pulses");
    send(1'b0, mk("srch_c3_after_abort", OPS, 0, 8'hC3, 0, 0, 0, 0), 1'b1);

    // Six-entry instance: addresses 6 and 7 are out of range.
    send(1'b1, mk("b_wr2_77",  OPW, 2, 8'h77, 0, 0, 0, 0), 1'b1);
    send(1'b1, mk("b_wr6_oob", OPW, 6, 8'h5A, 0, 0, 0, 1), 1'b1);
    send(1'b1, mk("b_wr7_oob", OPW, 7, 8'h77, 0, 0, 0, 1), 1'b1);
    send(1'b1, mk("b_srch_5a_miss", OPS, 0, 8'h5A, 0, 0, 0, 0), 1'b1);
    send(1'b1, mk("b_srch_77", OPS, 0, 8'h77, 1, 2, 0, 0), 1'b1);
    send(1'b1, mk("b_inv6_oob", OPI, 6, 8'h00, 0, 0, 0, 1), 1'b1);
    send(1'b1, mk("b_wr5_5a",  OPW, 5, 8'h5A, 0, 0, 0, 0), 1'b1);
    send(1'b1, mk("b_srch_5a_hit", OPS, 0, 8'h5A, 1, 5, 0, 0), 1'b1);
    send(1'b1, mk("b_clear",   OPC, 0, 8'h00, 0, 0, 0, 0), 1'b1);
    send(1'b1, mk("b_srch_77_cleared", OPS, 0, 8'h77, 0, 0, 0, 0), 1'b1);

    drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
